ex_muldiv_sequencer: RTL and testbench
======================================

// Module: ex_muldiv_sequencer
// PURPOSE
//  Iterative 16-bit unsigned multiply/divide sequencer for the execute stage of the 16-bit pipeline.
//  Accepts one MULTU/DIVU operation from the EX pipeline register and runs a shift-add multiply
//  or a restoring divide over WIDTH cycles. Holds the pipeline via stall_ex while busy and
//  delivers the result in architectural HI/LO registers.
// PARAMETERS
//  WIDTH    16                    operand width; iteration count = WIDTH
//  CNT_W    $clog2(WIDTH)+1       iteration counter width (localparam, derived)
// PORTS
//  clk          in   1      system clock; all state updates on the rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      EX holds a MULTU/DIVU instruction (decoded control, held while stalled)
//  op           in   1      0 = MULTU, 1 = DIVU
//  operand_a    in   WIDTH  multiplicand / dividend (read_data_1 from EX pipeline register)
//  operand_b    in   WIDTH  multiplier / divisor (read_data_2 from EX pipeline register)
//  flush        in   1      branch/exception flush of EX; aborts any operation in progress
//  stall_ex     out  1      freeze PC, IF/ID and ID/EX registers this cycle
//  done         out  1      one-cycle pulse: hi/lo hold the new result
//  hi           out  WIDTH  MULTU: product[2W-1:W]; DIVU: remainder
//  lo           out  WIDTH  MULTU: product[W-1:0]; DIVU: quotient
//  div_by_zero  out  1      sticky until next accepted op; set when DIVU has operand_b == 0
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, hi=lo=0, done=0, div_by_zero=0, stall_ex=0. rst overrides all inputs.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: if start && !flush at edge E0: latch op and operands, clear accumulators, counter=0,
//    clear div_by_zero, go RUN. flush in the same cycle wins: no accept.
//  - RUN: one iteration per edge. After exactly WIDTH edges in RUN (E1..EWIDTH), write hi/lo,
//    set done, go DONE.
//  - DONE: done=1 for this one cycle; start is ignored. The next edge returns to IDLE and clears done.
//  - stall_ex is combinational: (state==IDLE && start && !flush) || state==RUN. It is 0 in DONE,
//    so the instruction leaves EX in the same cycle the result becomes visible.
//  - Latency: accept at E0; done high in the cycle following E(WIDTH+1-1)=E16; back in IDLE after E17.
//  - MULTU: unsigned shift-add into a 2*WIDTH accumulator; {hi,lo} = a*b, exact with no overflow.
//  - DIVU: restoring, one quotient bit per iteration, MSB first; lo=a/b, hi=a%b.
//  - Divide by zero: full latency still runs; result is lo=16'hFFFF, hi=operand_a, div_by_zero=1.
//  - flush in RUN: next state IDLE; hi, lo and div_by_zero keep their previous values; no done.
//    flush in DONE: ignored, since the result is already committed.
//  - Operands change while busy: ignored; only values latched at accept are used.
//  - hi/lo change only in the RUN->DONE transition or on reset.
// STRUCTURE
//  - Shared package (muldiv_pkg): MD_OP_MULU=1'b0, MD_OP_DIVU=1'b1; state encoding
//    MD_IDLE=2'd0, MD_RUN=2'd1, MD_DONE=2'd2.
//  - Sub-module muldiv_datapath: operand/accumulator shift registers and add/subtract logic,
//    with load/step/op controls.
//  - FSM, counter, stall_ex, done and the hi/lo registers stay in ex_muldiv_sequencer.
// TESTING
//  1. rst high for 2 cycles -> all outputs 0. Then MULTU a=3, b=1 -> stall_ex=1 for 17 cycles,
//     done at cycle 17, hi=0, lo=3.
//  2. MULTU a=16'hFFFF, b=16'hFFFF -> hi=16'hFFFE, lo=16'h0001, done single pulse.
//  3. DIVU a=100, b=7 -> lo=14, hi=2, div_by_zero=0.
//  4. DIVU a=5, b=0 -> lo=16'hFFFF, hi=5, div_by_zero=1. A following MULTU 2*2 clears
//     div_by_zero at accept and gives lo=4.
//  5. MULTU 9*9, then flush at RUN iteration 5 -> stall_ex=0 the next cycle, no done,
//     hi/lo keep the previous result.
//  6. start held high through DONE, and rst asserted mid-RUN -> exactly one done per accepted op;
//     after rst all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the execute-stage multiply/divide sequencer:
//   - operation encoding driven on the sequencer's op input
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic MD_OP_MULU = 1'b0;
    localparam logic MD_OP_DIVU = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// Operand and accumulator registers for the iterative unsigned multiply/divide.
// One iteration is applied per i_step; the combinational result of the current
// iteration is exposed on o_acc_next so the controller can commit the final
// iteration directly into its result registers.
//
// Accumulator layout (both operations):
//   MULTU: upper half = partial product, lower half = remaining multiplier bits
//   DIVU : upper half = partial remainder, lower half = dividend bits / quotient
// so after WIDTH iterations {hi, lo} = accumulator for either operation.
//
// Ports
//   clk        in   1         clock
//   i_load     in   1         capture op and operands, clear accumulator top
//   i_step     in   1         apply one iteration
//   i_op       in   1         operation at load (MD_OP_MULU / MD_OP_DIVU)
//   i_a        in   WIDTH     multiplicand / dividend
//   i_b        in   WIDTH     multiplier / divisor
//   o_acc_next out  2*WIDTH   accumulator value after the current iteration
// -----------------------------------------------------------------------------
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic               r_op;
    logic [WIDTH-1:0]   r_opnd;     // addend (MULTU) or divisor (DIVU)
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;

    always_comb begin
        // Shift-add: add the multiplicand into the top half when the current
        // multiplier LSB is set; the carry becomes the new MSB after the shift.
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

        // Restoring divide: remainder shifted left with the next dividend bit.
        // The shifted value can be WIDTH+1 bits wide, but whenever it is
        // >= divisor the difference fits in WIDTH bits, so a modulo subtract
        // of the low bits is exact.
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

        if (r_op == MD_OP_DIVU) begin
            o_acc_next = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};
        end else begin
            o_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_op   <= i_op;
            r_opnd <= (i_op == MD_OP_DIVU) ? i_b : i_a;
            r_acc  <= {{WIDTH{1'b0}}, ((i_op == MD_OP_DIVU) ? i_a : i_b)};
        end else if (i_step) begin
            r_acc  <= o_acc_next;
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// ex_muldiv_sequencer
// Iterative unsigned MULTU/DIVU unit for the execute stage. An operation is
// accepted from the EX pipeline register, iterated for WIDTH cycles while the
// pipeline is stalled, and committed into the architectural HI/LO registers.
//
// Ports
//   clk          in   1      clock
//   rst          in   1      synchronous active-high reset
//   start        in   1      EX holds a MULTU/DIVU (held while stalled)
//   op           in   1      0 = MULTU, 1 = DIVU
//   operand_a    in   WIDTH  multiplicand / dividend
//   operand_b    in   WIDTH  multiplier / divisor
//   flush        in   1      abort the operation in EX
//   stall_ex     out  1      freeze PC, IF/ID and ID/EX this cycle
//   done         out  1      one-cycle pulse: hi/lo hold the new result
//   hi           out  WIDTH  product high half / remainder
//   lo           out  WIDTH  product low half / quotient
//   div_by_zero  out  1      sticky flag for DIVU with zero divisor
// -----------------------------------------------------------------------------
module ex_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             stall_ex,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_t          r_state;
    md_state_t          w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;
    logic               r_dbz_pend;     // accepted op is a DIVU by zero
    logic [WIDTH-1:0]   r_a_hold;       // dividend, returned as remainder on divide by zero

    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc_next;

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_op       (op),
        .i_a        (operand_a),
        .i_b        (operand_b),
        .o_acc_next (w_acc_next)
    );

    // Counter holds the number of iterations already applied; the iteration
    // taken while it reads WIDTH-1 is the final one.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        stall_ex     = 1'b0;
        done         = 1'b0;

        case (r_state)
            MD_IDLE: begin
                if (start && !flush) begin
                    w_load       = 1'b1;
                    stall_ex     = 1'b1;
                    w_state_next = MD_RUN;
                end
            end
            MD_RUN: begin
                stall_ex = 1'b1;
                if (flush) begin
                    w_state_next = MD_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_finish     = 1'b1;
                        w_state_next = MD_DONE;
                    end
                end
            end
            MD_DONE: begin
                // Stall drops here so the instruction leaves EX as the
                // result becomes visible; a held start is not re-sampled.
                done         = 1'b1;
                w_state_next = MD_IDLE;
            end
            default: begin
                w_state_next = MD_IDLE;
            end
        endcase

        // Reset dominates every input, including the combinational stall.
        if (rst) begin
            w_load   = 1'b0;
            w_step   = 1'b0;
            w_finish = 1'b0;
            stall_ex = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MD_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dbz      <= 1'b0;
            r_dbz_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_load) begin
                r_cnt      <= '0;
                r_dbz      <= 1'b0;
                r_dbz_pend <= (op == MD_OP_DIVU) && (operand_b == '0);
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_finish) begin
                if (r_dbz_pend) begin
                    r_hi  <= r_a_hold;
                    r_lo  <= '1;
                    r_dbz <= 1'b1;
                end else begin
                    r_hi  <= w_acc_next[2*WIDTH-1:WIDTH];
                    r_lo  <= w_acc_next[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_a_hold <= operand_a;
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic        flush;
    logic        stall_ex;
    logic        done;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    // Last committed architectural result, tracked from the reference model.
    logic [15:0] exp_hi;
    logic [15:0] exp_lo;
    logic        exp_dbz;

    always #5 clk = ~clk;

    ex_muldiv_sequencer #(
        .WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .stall_ex    (stall_ex),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    // Reference: {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [32:0] ref_model(input logic o, input logic [15:0] a, input logic [15:0] b);
        if (o == 1'b0) return {1'b0, 32'(a) * 32'(b)};
        if (b == 16'd0) return {1'b1, a, 16'hFFFF};
        return {1'b0, a % b, a / b};
    endfunction

    // Drive one operation and collect what the DUT shows; operands are
    // scrambled once the op is accepted. done_at = -1 when done never came.
    task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b, input bit hold,
                          output int stalls, output int done_at,
                          output logic [15:0] rhi, output logic [15:0] rlo, output logic rdbz,
                          output logic dbz_after_accept, output logic stall_at_done);
        stalls = 0;
        done_at = -1;
        rhi = 'x;
        rlo = 'x;
        rdbz = 1'bx;
        dbz_after_accept = 1'bx;
        stall_at_done = 1'bx;
        @(negedge clk);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done) begin
                done_at = i;
                rhi = hi;
                rlo = lo;
                rdbz = div_by_zero;
                stall_at_done = stall_ex;
                break;
            end
            if (stall_ex) stalls++;
            if (i == 1) begin
                dbz_after_accept = div_by_zero;
                operand_a = 16'($urandom);
                operand_b = 16'($urandom);
                op = ~o;
            end
            @(negedge clk);
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 1'b0;
        operand_a = 16'd0; operand_b = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if ({stall_ex, done, div_by_zero} !== 3'b000)
            $display("FAIL reset_ctrl: got stall/done/dbz=%b want 000", {stall_ex, done, div_by_zero});
        else n_pass++;
        n_total++;
        if ({hi, lo} !== 32'd0) $display("FAIL reset_hilo: got %h want 00000000", {hi, lo});
        else n_pass++;
        rst = 1'b0;
        exp_hi = 16'd0; exp_lo = 16'd0; exp_dbz = 1'b0;
    endtask

    task automatic test_mul_basic();
        int st, da; logic [15:0] rh, rl; logic rd, dba, sad;
        run_op(1'b0, 16'd3, 16'd1, 1'b0, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if (st !== 17) $display("FAIL mul3_stall_cycles: got %0d want 17", st); else n_pass++;
        n_total++;
        if (da !== 17) $display("FAIL mul3_done_cycle: got %0d want 17", da); else n_pass++;
        n_total++;
        if ({rh, rl} !== 32'd3) $display("FAIL mul3_result: got %h want 00000003", {rh, rl}); else n_pass++;
        n_total++;
        if (sad !== 1'b0) $display("FAIL mul3_stall_in_done: got %b want 0", sad); else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL mul3_done_pulse: got %b want 0", done); else n_pass++;
        exp_hi = 16'd0; exp_lo = 16'd3;
    endtask

    task automatic test_mul_max();
        int st, da; logic [15:0] rh, rl; logic rd, dba, sad;
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if ({rh, rl} !== 32'hFFFE_0001) $display("FAIL mul_max_result: got %h want fffe0001", {rh, rl}); else n_pass++;
        n_total++;
        if (da !== 17) $display("FAIL mul_max_done_cycle: got %0d want 17", da); else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (done !== 1'b0) $display("FAIL mul_max_done_pulse: got %b want 0", done); else n_pass++;
        exp_hi = 16'hFFFE; exp_lo = 16'h0001;
    endtask

    task automatic test_div_basic();
        int st, da; logic [15:0] rh, rl; logic rd, dba, sad;
        run_op(1'b1, 16'd100, 16'd7, 1'b0, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if ({rd, rh, rl} !== {1'b0, 16'd2, 16'd14})
            $display("FAIL div100_7: got dbz=%b hi=%0d lo=%0d want dbz=0 hi=2 lo=14", rd, rh, rl);
        else n_pass++;
        n_total++;
        if (da !== 17) $display("FAIL div100_7_done_cycle: got %0d want 17", da); else n_pass++;
        exp_hi = 16'd2; exp_lo = 16'd14; exp_dbz = 1'b0;
    endtask

    task automatic test_div_zero();
        int st, da; logic [15:0] rh, rl; logic rd, dba, sad;
        run_op(1'b1, 16'd5, 16'd0, 1'b0, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if ({rd, rh, rl} !== {1'b1, 16'd5, 16'hFFFF})
            $display("FAIL div_zero: got dbz=%b hi=%h lo=%h want dbz=1 hi=0005 lo=ffff", rd, rh, rl);
        else n_pass++;
        n_total++;
        if (da !== 17) $display("FAIL div_zero_done_cycle: got %0d want 17", da); else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (div_by_zero !== 1'b1) $display("FAIL div_zero_sticky: got %b want 1", div_by_zero); else n_pass++;
        run_op(1'b0, 16'd2, 16'd2, 1'b0, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if (dba !== 1'b0) $display("FAIL dbz_clear_at_accept: got %b want 0", dba); else n_pass++;
        n_total++;
        if ({rd, rh, rl} !== {1'b0, 16'd0, 16'd4})
            $display("FAIL mul2_2: got dbz=%b hi=%h lo=%h want dbz=0 hi=0000 lo=0004", rd, rh, rl);
        else n_pass++;
        exp_hi = 16'd0; exp_lo = 16'd4; exp_dbz = 1'b0;
    endtask

    task automatic test_flush();
        int dones;
        @(negedge clk);
        start = 1'b1; op = 1'b0; operand_a = 16'd9; operand_b = 16'd9;
        repeat (5) @(negedge clk);
        #1;
        n_total++;
        if (stall_ex !== 1'b1) $display("FAIL flush_pre_stall: got %b want 1", stall_ex); else n_pass++;
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_total++;
        if (stall_ex !== 1'b0) $display("FAIL flush_stall_drop: got %b want 0", stall_ex); else n_pass++;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk); #1;
        end
        n_total++;
        if (dones !== 0) $display("FAIL flush_no_done: got %0d done pulses want 0", dones); else n_pass++;
        n_total++;
        if ({div_by_zero, hi, lo} !== {exp_dbz, exp_hi, exp_lo})
            $display("FAIL flush_keep_result: got dbz=%b hi=%h lo=%h want dbz=%b hi=%h lo=%h",
                     div_by_zero, hi, lo, exp_dbz, exp_hi, exp_lo);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int st, da, dones; logic [15:0] rh, rl; logic rd, dba, sad;
        run_op(1'b0, 16'd7, 16'd6, 1'b1, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if ({rh, rl} !== 32'd42 || da !== 17)
            $display("FAIL b2b_first: got result=%h at cycle %0d want 0000002a at 17", {rh, rl}, da);
        else n_pass++;
        n_total++;
        if (sad !== 1'b0) $display("FAIL b2b_stall_in_done: got %b want 0", sad); else n_pass++;
        // start still high: the following IDLE cycle accepts a new op
        run_op(1'b0, 16'd7, 16'd6, 1'b0, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if (da !== 17 || st !== 17)
            $display("FAIL b2b_second_timing: got done at %0d stalls %0d want 17 and 17", da, st);
        else n_pass++;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (done) dones++;
        end
        n_total++;
        if (dones !== 0) $display("FAIL b2b_extra_done: got %0d done pulses want 0", dones); else n_pass++;
        exp_hi = 16'd0; exp_lo = 16'd42;
    endtask

    task automatic test_rst_mid_run();
        int st, da, dones; logic [15:0] rh, rl; logic rd, dba, sad;
        @(negedge clk);
        start = 1'b1; op = 1'b1; operand_a = 16'd1000; operand_b = 16'd3;
        repeat (6) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({stall_ex, done, div_by_zero, hi, lo} !== 35'd0)
            $display("FAIL rst_mid_run_outputs: got stall=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                     stall_ex, done, div_by_zero, hi, lo);
        else n_pass++;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (done) dones++;
        end
        n_total++;
        if (dones !== 0) $display("FAIL rst_mid_run_no_done: got %0d want 0", dones); else n_pass++;
        run_op(1'b0, 16'd2, 16'd3, 1'b0, st, da, rh, rl, rd, dba, sad);
        n_total++;
        if ({rh, rl} !== 32'd6 || da !== 17)
            $display("FAIL rst_then_op: got result=%h at cycle %0d want 00000006 at 17", {rh, rl}, da);
        else n_pass++;
        exp_hi = 16'd0; exp_lo = 16'd6; exp_dbz = 1'b0;
    endtask

    task automatic test_random();
        int st, da; logic [15:0] rh, rl; logic rd, dba, sad;
        logic o; logic [15:0] a, b; logic [32:0] exp;
        for (int n = 0; n < 24; n++) begin
            o = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
            exp = ref_model(o, a, b);
            run_op(o, a, b, 1'b0, st, da, rh, rl, rd, dba, sad);
            n_total++;
            if ({rd, rh, rl} !== exp || da !== 17)
                $display("FAIL rand_%0d op=%b a=%h b=%h: got dbz=%b hi=%h lo=%h at cycle %0d want dbz=%b hi=%h lo=%h at 17",
                         n, o, a, b, rd, rh, rl, da, exp[32], exp[31:16], exp[15:0]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_max();
        test_div_basic();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_rst_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
